// File: rtl/rd_slot_arbiter.sv
// Round-robin arbiter that shares one buffer read port among N_CH requesters.
// A single slot sequencer drives the word address and a timed rd strobe for the granted channel.
module rd_slot_arbiter #(
    parameter int N_CH     = 5,
    parameter int WORDS    = 18,
    parameter int AW       = 5,
    parameter int SLOT     = 64,
    parameter int RD_START = 40,
    parameter int RD_LEN   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic [N_CH-1:0] en,
    output logic [N_CH-1:0] grant,
    output logic [2:0]      rd_sel,
    output logic [AW-1:0]   rd_adr,
    output logic            rd,
    output logic [N_CH-1:0] done,
    output logic            busy
);
    localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT - 1);
    localparam logic [CW-1:0] RD_ON     = CW'(RD_START);
    localparam logic [CW-1:0] RD_OFF    = CW'(RD_START + RD_LEN - 1);
    localparam logic [AW-1:0] WORD_LAST = AW'(WORDS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] prev;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] capture;
    logic [N_CH-1:0] finish;
    logic [0:0]      state;
    logic [2:0]      last;
    logic [2:0]      pick;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic            slot_end;
    logic            burst_end;

    assign capture   = sync2 & ~prev & en;
    assign slot_end  = (state == BURST) && (cnt == CNT_LAST);
    assign burst_end = slot_end && (rd_adr == WORD_LAST);
    assign finish    = burst_end ? grant : '0;
    assign cnt_nx    = slot_end ? '0 : cnt + CW'(1);

    // Scan from the farthest offset down so the nearest pending channel after last wins.
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        idx  = 0;
        pick = '0;
        for (int off = N_CH; off >= 1; off--) begin
            idx = (int'(last) + off) % N_CH;
            if (pending[idx]) pick = 3'(idx);
        end
    end

    // NOTE: non-blocking assignments make every flop below see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            pending <= '0;
            state   <= IDLE;
            last    <= 3'(N_CH - 1);
            grant   <= '0;
            rd_sel  <= '0;
            rd_adr  <= '0;
            rd      <= 1'b0;
            done    <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= req;
            sync2   <= sync1;
            prev    <= sync2;
            // The finishing channel's clear beats a same-cycle capture of that channel.
            pending <= (pending | capture) & ~finish;
            done    <= finish;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state  <= BURST;
                        grant  <= N_CH'(1) << pick;
                        rd_sel <= pick;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        rd_adr <= '0;
                    end
                end
                BURST: begin
                    cnt <= cnt_nx;
                    rd  <= (cnt_nx >= RD_ON) && (cnt_nx <= RD_OFF);
                    if (burst_end) begin
                        state  <= IDLE;
                        grant  <= '0;
                        rd_sel <= '0;
                        rd_adr <= '0;
                        busy   <= 1'b0;
                        last   <= rd_sel;
                    end else if (slot_end) begin
                        rd_adr <= rd_adr + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rd_slot_arbiter.sv
// Self-checking bench for rd_slot_arbiter: directed scenarios plus random request traffic,
// compared every cycle against a time-based reference model of the arbiter.
module tb_rd_slot_arbiter;
    localparam int N_CH      = 5;
    localparam int WORDS     = 18;
    localparam int AW        = 5;
    localparam int SLOT      = 64;
    localparam int RD_START  = 40;
    localparam int RD_LEN    = 4;
    localparam int BURST_LEN = WORDS * SLOT;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] grant;
    logic [2:0]      rd_sel;
    logic [AW-1:0]   rd_adr;
    logic            rd;
    logic [N_CH-1:0] done;
    logic            busy;

    rd_slot_arbiter #(
        .N_CH(N_CH), .WORDS(WORDS), .AW(AW),
        .SLOT(SLOT), .RD_START(RD_START), .RD_LEN(RD_LEN)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .en(en), .grant(grant), .rd_sel(rd_sel),
        .rd_adr(rd_adr), .rd(rd), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: request history seen by the capture logic, pending set,
    // owner channel and cycles elapsed since its grant.
    logic [N_CH-1:0] hist0, hist1, hist2, m_pend, m_done;
    int m_owner, m_last, m_t, m_bursts;

    // Observed-event bookkeeping for the directed checks.
    int cyc, rd_rises, rd_hi, adr_sum, done_cnt, grant_cnt, order_code;
    int first_grant, first_rd, done_at, fall_at, gaps, gap_bad, rd_orphan;
    logic rd_q;
    logic [N_CH-1:0] grant_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [N_CH-1:0] v);
        for (int i = 0; i < N_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist0 = '0; hist1 = '0; hist2 = '0;
        m_pend = '0; m_done = '0;
        m_owner = -1; m_last = N_CH - 1; m_t = 0;
    endtask

    task automatic model_edge();
        logic [N_CH-1:0] cap;
        logic [N_CH-1:0] clr;
        int k;
        if (!rst) begin
            model_reset();
        end else begin
            cap = hist1 & ~hist2 & en;
            hist2 = hist1; hist1 = hist0; hist0 = req;
            clr = '0;
            if (m_owner < 0) begin
                if (m_pend != '0) begin
                    for (int off = 1; off <= N_CH; off++) begin
                        k = (m_last + off) % N_CH;
                        if (m_pend[k] && m_owner < 0) m_owner = k;
                    end
                    m_t = 0;
                end
            end else if (m_t == BURST_LEN - 1) begin
                clr[m_owner] = 1'b1;
                m_last = m_owner;
                m_owner = -1;
                m_t = 0;
                m_bursts++;
            end else begin
                m_t++;
            end
            m_done = clr;
            m_pend = (m_pend | cap) & ~clr;
        end
    endtask

    task automatic compare_all();
        logic [N_CH-1:0] eg;
        logic [2:0]      es;
        logic [AW-1:0]   ea;
        logic            er;
        eg = '0; es = '0; ea = '0; er = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            es = 3'(m_owner);
            ea = AW'(m_t / SLOT);
            er = ((m_t % SLOT) >= RD_START) && ((m_t % SLOT) < RD_START + RD_LEN);
        end
        check($sformatf("cycle%0d", cyc), 32'({grant, rd_sel, rd_adr, rd, done, busy}),
              32'({eg, es, ea, er, m_done, m_owner >= 0}));
    endtask

    task automatic record_events();
        cyc++;
        if (rd && !rd_q) begin
            rd_rises++;
            adr_sum += int'(rd_adr);
            if (first_rd < 0) first_rd = cyc;
        end
        if (rd) rd_hi++;
        if (rd && grant == '0) rd_orphan++;
        if (grant != '0 && grant_q == '0) begin
            grant_cnt++;
            order_code = order_code * 8 + lowest(grant);
            if (first_grant < 0) first_grant = cyc;
            if (fall_at >= 0) begin
                gaps++;
                if (cyc - fall_at != 1) gap_bad++;
            end
        end
        if (grant == '0 && grant_q != '0) fall_at = cyc;
        if (done != '0) begin
            done_cnt++;
            done_at = cyc;
        end
        rd_q = rd;
        grant_q = grant;
    endtask

    task automatic clear_events();
        rd_rises = 0; rd_hi = 0; adr_sum = 0; done_cnt = 0; grant_cnt = 0; order_code = 0;
        first_grant = -1; first_rd = -1; done_at = -1; fall_at = -1;
        gaps = 0; gap_bad = 0; rd_orphan = 0; m_bursts = 0;
        rd_q = rd; grant_q = grant;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
            record_events();
        end
    endtask

    task automatic do_reset();
        req = '0;
        en  = '1;
        rst = 1'b0;
        #1;
        model_reset();
        tick(3);
        rst = 1'b1;
        tick(3);
        clear_events();
    endtask

    initial begin
        int idx;
        rst = 1'b0; req = '0; en = '1; cyc = 0; m_bursts = 0;
        model_reset();
        #1;
        check("reset_outputs", 32'({grant, rd_sel, rd_adr, rd, done, busy}), 32'(0));
        tick(2);
        rst = 1'b1;
        tick(3);
        clear_events();

        // Single request on channel 0.
        req[0] = 1'b1;
        tick(4);
        check("t1_grant", 32'(grant), 32'(5'b00001));
        check("t1_busy", 32'(busy), 32'(1));
        tick(BURST_LEN);
        check("t1_first_rd_delay", first_rd - first_grant, RD_START);
        check("t1_done_delay", done_at - first_grant, BURST_LEN);
        check("t1_rd_pulses", rd_rises, WORDS);
        check("t1_rd_high", rd_hi, WORDS * RD_LEN);
        check("t1_adr_sum", adr_sum, WORDS * (WORDS - 1) / 2);
        check("t1_done_bit", 32'(done), 32'(5'b00001));
        tick(1);
        check("t1_idle_after", 32'({grant, busy, done}), 32'(0));

        // All five channels request together.
        do_reset();
        req = '1;
        tick(4 + 5 * (BURST_LEN + 1) + 8);
        check("t2_grant_count", grant_cnt, 5);
        check("t2_grant_order", order_code, 'o1234);
        check("t2_done_count", done_cnt, 5);
        check("t2_gaps", gaps, 4);
        check("t2_gap_not_one", gap_bad, 0);
        check("t2_rd_without_grant", rd_orphan, 0);
        check("t2_rd_pulses", rd_rises, 5 * WORDS);

        // Channel 2 bursting while 1 then 3 request: 3 must follow 2.
        do_reset();
        req[2] = 1'b1;
        tick(4);
        check("t3_grant2", 32'(grant), 32'(5'b00100));
        tick(100);
        req[1] = 1'b1;
        tick(50);
        req[3] = 1'b1;
        tick(3 * (BURST_LEN + 1) + 10);
        check("t3_grant_count", grant_cnt, 3);
        check("t3_grant_order", order_code, 'o231);
        check("t3_done_count", done_cnt, 3);

        // Re-toggling req[0] during its own burst must not queue another.
        do_reset();
        req[0] = 1'b1;
        tick(204);
        req[0] = 1'b0;
        tick(10);
        req[0] = 1'b1;
        tick(BURST_LEN + 200);
        check("t4_grant_count", grant_cnt, 1);
        check("t4_done_count", done_cnt, 1);
        check("t4_busy", 32'(busy), 32'(0));

        // Held-high level gives exactly one burst.
        do_reset();
        req[4] = 1'b1;
        tick(5000);
        check("t5_grant_count", grant_cnt, 1);
        check("t5_done_count", done_cnt, 1);

        // Disabled channel drops its edge; enabling later with req held does not retrigger.
        do_reset();
        en = 5'b10111;
        req[3] = 1'b1;
        tick(20);
        check("t6_no_grant", grant_cnt, 0);
        check("t6_busy", 32'(busy), 32'(0));
        en = '1;
        tick(20);
        check("t6_no_grant_level", grant_cnt, 0);

        // Reset in the middle of word 7 while rd is high.
        do_reset();
        req[1] = 1'b1;
        tick(4 + 7 * SLOT + RD_START + 1);
        check("t7_rd_before", 32'(rd), 32'(1));
        check("t7_adr_before", 32'(rd_adr), 32'(7));
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("t7_abort", 32'({grant, rd, busy, done, rd_adr, rd_sel}), 32'(0));
        tick(3);
        check("t7_no_done", done_cnt, 0);
        rst = 1'b1;
        req = '0;
        tick(5);
        clear_events();
        req[1] = 1'b1;
        tick(4);
        check("t7_regrant", 32'(grant), 32'(5'b00010));
        check("t7_adr_restart", 32'(rd_adr), 32'(0));
        tick(RD_START);
        check("t7_first_rd", 32'({rd, rd_adr}), 32'({1'b1, 5'd0}));

        // Random request and enable traffic against the model.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(39) == 0) begin
                idx = int'($urandom_range(N_CH - 1));
                req[idx] = ~req[idx];
            end
            if ($urandom_range(199) == 0) en = N_CH'($urandom);
            tick(1);
        end
        check("t8_done_count", done_cnt, m_bursts);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rd_slot_arbiter.md
Name: rd_slot_arbiter

Overview:
- Shares one buffer read port among N_CH UART-side requesters.
- Each requester asks for a burst of WORDS words. The arbiter grants one channel at a time in round-robin order.
- For the granted channel it generates the read address and a timed RD strobe per word, one fixed-length slot per word.
- It replaces hard-wired per-channel chaining of read sequencers with a single sequencer plus an arbiter.

Parameters:
- N_CH, 5: number of requesting channels.
- WORDS, 18: words per burst. Addresses run 0..WORDS-1.
- AW, 5: read address width. Must satisfy 2^AW >= WORDS.
- SLOT, 64: clock cycles per word slot.
- RD_START, 40: slot count at which rd rises.
- RD_LEN, 4: rd high time in cycles. Must satisfy RD_START+RD_LEN <= SLOT.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- req, input, N_CH: per-channel request strobes, level, asynchronous to clk.
- en, input, N_CH: per-channel enable. A request edge on a disabled channel is dropped.
- grant, output, N_CH: one-hot. Bit i is high for the whole burst of channel i.
- rd_sel, output, 3: index of the granted channel. 0 when idle.
- rd_adr, output, AW: current word address. 0 when idle.
- rd, output, 1: shared read strobe. rd_sel identifies the owner.
- done, output, N_CH: one-cycle pulse on bit i when channel i finishes its burst.
- busy, output, 1: high while any burst is in progress.

Behaviour:
- Reset (async, rst=0):
  - All outputs are 0.
  - Pending flags are 0.
  - Synchronisers are 0.
  - Round-robin pointer last = N_CH-1.
  - State = IDLE.
  - Asserting rst mid-burst aborts the burst immediately, with no done pulse.
- Input sync and capture:
  - Each req bit passes through a 2-flop synchroniser, then a registered edge detector.
  - pending[i] sets on the edge where sync[i]=1, previous=0 and en[i]=1.
  - A held-high level does not re-trigger.
  - An edge while pending[i] is already set, including during channel i's own burst, is ignored.
- FSM states: IDLE, BURST.
- IDLE:
  - If any pending bit is set, pick the first pending index scanning last+1, last+2, ... modulo N_CH.
  - On the next edge: state=BURST, grant[k]=1, rd_sel=k, busy=1, slot counter=0, word=0.
  - With no pending bits: stay in IDLE, busy=0.
- BURST:
  - The slot counter increments every cycle, 0..SLOT-1.
  - rd=1 exactly while the slot counter is in RD_START..RD_START+RD_LEN-1 (registered: rd rises on the edge where the count becomes RD_START).
  - rd_adr = word and stays stable across the whole slot.
  - At slot count SLOT-1 with word<WORDS-1: word increments and the slot counter wraps to 0.
  - At slot count SLOT-1 with word=WORDS-1, on the next edge:
    - grant=0, rd_sel=0, rd_adr=0, busy=0;
    - done[k]=1 for one cycle;
    - pending[k] clears, last=k, state=IDLE.
- Burst timing:
  - Burst length is WORDS*SLOT cycles: 1152 at the defaults.
  - The first rd rises RD_START cycles after grant.
  - There is always exactly one IDLE cycle between consecutive bursts.
- Simultaneous events:
  - A capture edge for k in the same cycle that pending[k] clears is dropped (clear wins).
  - Captures for other channels during a burst are kept.
- Latency:
  - req rising to pending set: 3 clk edges.
  - pending set to grant: 1 edge, if IDLE.
- en:
  - en only gates capture.
  - Deasserting en[i] after pending[i] is set does not cancel the request or a running burst.

Test Plan:
- Single request on channel 0 after reset:
  - grant=00001;
  - 18 rd pulses, each 4 cycles wide, on rd_adr 0..17;
  - first rd exactly 40 cycles after grant;
  - done[0] pulse 1152 cycles after grant; busy low afterwards.
- req=11111 in the same cycle after reset:
  - grants in order 0,1,2,3,4;
  - one IDLE cycle between bursts;
  - five done pulses;
  - rd never overlaps between channels.
- Channel 2 in burst while channels 1 and 3 raise req:
  - after done[2], channel 3 is granted before channel 1.
- Toggle req[0] low→high during channel 0's own burst:
  - no second burst follows (pending was already set).
- req[4] held high for 5000 cycles:
  - exactly one burst.
- en[3]=0 with a req[3] edge:
  - no grant.
- rst asserted at word 7 of a burst:
  - grant, rd and busy are 0 immediately, with no done pulse;
  - after release, a new req edge restarts from rd_adr 0.
